// File: rtl/iomem_initiator.sv
// iomem_initiator: single-outstanding iomem bus master with timeout watchdog.
module iomem_initiator #(
    parameter int          TIMEOUT_CYCLES = 64,
    parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [31:0] cmd_addr_i,
    input  logic [31:0] cmd_wdata_i,
    input  logic [3:0]  cmd_wstrb_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        iomem_valid_o,
    input  logic        iomem_ready_i,
    output logic [3:0]  iomem_wstrb_o,
    output logic [31:0] iomem_addr_o,
    output logic [31:0] iomem_wdata_o,
    input  logic [31:0] iomem_rdata_i,
    output logic        busy_o
);
    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

    typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt;
    logic          live;
    logic          accept;
    logic          timeout;

    // live keeps cmd_ready_o low while in reset and rises on the first clock after release
    assign cmd_ready_o   = live && state == IDLE;
    assign iomem_valid_o = state == REQ;
    assign rsp_valid_o   = state == RSP;
    assign busy_o        = state != IDLE;
    assign accept        = cmd_valid_i && cmd_ready_o;
    assign timeout       = cnt == CW'(TIMEOUT_CYCLES - 1);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    state_nx = accept ? REQ : IDLE;
            REQ:     state_nx = (iomem_ready_i || timeout) ? RSP : REQ;
            RSP:     state_nx = rsp_ready_i ? IDLE : RSP;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            live          <= 1'b0;
            cnt           <= '0;
            iomem_addr_o  <= '0;
            iomem_wdata_o <= '0;
            iomem_wstrb_o <= '0;
            rsp_rdata_o   <= '0;
            rsp_err_o     <= 1'b0;
        end else begin
            live <= 1'b1;
            if (accept) begin
                iomem_addr_o  <= cmd_addr_i;
                iomem_wdata_o <= cmd_wdata_i;
                iomem_wstrb_o <= cmd_wstrb_i;
                cnt           <= '0;
            end
            // ready is tested before timeout so a late completion still succeeds
            if (state == REQ) begin
                if (iomem_ready_i) begin
                    rsp_rdata_o <= iomem_rdata_i;
                    rsp_err_o   <= 1'b0;
                end else if (timeout) begin
                    rsp_rdata_o <= ERR_RDATA;
                    rsp_err_o   <= 1'b1;
                end else if (cnt != '1) begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end
endmodule
